uart_rx_param: RTL and testbench

- Parametrised UART receiver; successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count, set at build time.
- Adds a 2-flop input synchronizer, false-start rejection, framing/parity error flags, and a valid/ready output handshake with overrun detection.
- Sits between the board RX pin and the CPU-side UART/MMIO register block, in the 50 MHz clock domain.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_param_if.sv | 12 +
 rtl/uart_bit_sampler.sv | 38 +++
 rtl/uart_rx_param.sv | 88 ++++++++
 tb/tb_uart_rx_param.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encodings, parity modes and clog2 helper
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: received-frame valid/ready bus with data and error flags
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  modport master (output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
  modport slave  (input rx_data, rx_valid, parity_err, frame_err, output rx_ready);
endinterface

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: rx synchronizer, bit-period counter and mid-bit sample strobe; UART_RX_MAJORITY_EN selects a 2-of-3 vote
module uart_bit_sampler import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic clr,
  output logic rx_s,
  output logic sample_stb,
  output logic sample_bit
);
  localparam int CW  = clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  logic          r_meta, r_sync;
  logic [CW-1:0] r_cnt;
  // two-flop synchronizer, reset high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_meta, r_sync} <= 2'b11;
    else {r_meta, r_sync} <= {rx, r_meta};
  // bit-period counter, held at zero while the receiver is idle
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (clr || r_cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : r_cnt + CW'(1);
  assign rx_s = r_sync;
`ifdef UART_RX_MAJORITY_EN
  logic r_h1, r_h2;
  // rx_s history so the vote at MID+1 sees the MID-1, MID and MID+1 samples
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_h1, r_h2} <= 2'b11;
    else {r_h1, r_h2} <= {r_sync, r_h1};
  assign sample_stb = r_cnt == CW'(MID + 1);
  assign sample_bit = (r_sync & r_h1) | (r_sync & r_h2) | (r_h1 & r_h2);
`else
  assign sample_stb = r_cnt == CW'(MID);
  assign sample_bit = r_sync;
`endif
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with valid/ready output, error flags and sticky overrun; UART_RX_MAJORITY_EN enables majority sampling
module uart_rx_param import uart_pkg::*; #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 9600,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            overrun_clr,
  uart_rx_param_if.master bus,
  output logic            overrun,
  output logic            busy
);
  logic [2:0]           r_state;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_armed, r_perr_f, r_ferr_f;
  logic                 r_valid, r_perr, r_ferr, r_ovr;
  logic                 w_rx_s, w_stb, w_bit, w_commit, w_hs, w_load;
  uart_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_smp (
    .clk(clk), .rst(rst), .rx(rx), .clr(r_state == ST_IDLE),
    .rx_s(w_rx_s), .sample_stb(w_stb), .sample_bit(w_bit)
  );
  assign w_commit = r_state == ST_STOP && w_stb && r_idx == 4'(STOP_BITS - 1);
  assign w_hs     = r_valid & bus.rx_ready;
  assign w_load   = w_commit & (~r_valid | w_hs);
  // frame FSM; a start needs a high-to-low edge so a held-low break never retriggers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_shift  <= '0;
      r_armed  <= 1'b1;
      r_perr_f <= 1'b0;
      r_ferr_f <= 1'b0;
    end else begin
      r_armed <= w_rx_s;
      case (r_state)
        ST_IDLE: if (r_armed && !w_rx_s) r_state <= ST_START;
        ST_START: if (w_stb) begin
          r_state  <= w_bit ? ST_IDLE : ST_DATA;
          r_idx    <= '0;
          r_perr_f <= 1'b0;
          r_ferr_f <= 1'b0;
        end
        ST_DATA: if (w_stb) begin
          r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
          r_idx   <= (r_idx == 4'(DATA_BITS - 1)) ? '0 : r_idx + 4'd1;
          if (r_idx == 4'(DATA_BITS - 1)) r_state <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: if (w_stb) begin
          r_perr_f <= ^r_shift ^ w_bit ^ (PARITY_MODE == PARITY_ODD);
          r_state  <= ST_STOP;
        end
        ST_STOP: if (w_stb) begin
          r_ferr_f <= r_ferr_f | ~w_bit;
          r_idx    <= r_idx + 4'd1;
          if (w_commit) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  // output holding register: load on commit when free, drop and flag overrun when full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_valid <= w_load | (r_valid & ~w_hs);
      r_data  <= w_load ? r_shift : r_data;
      r_perr  <= w_load ? (PARITY_MODE != PARITY_NONE) & r_perr_f : r_perr & ~w_hs;
      r_ferr  <= w_load ? r_ferr_f | ~w_bit : r_ferr & ~w_hs;
      r_ovr   <= (w_commit & ~w_load) | (r_ovr & ~overrun_clr);
    end
  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign overrun        = r_ovr;
  assign busy           = r_state != ST_IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench driving 8N1, 7E1 and 8N2 receivers with a frame-level reference model
module tb_uart_rx_param;
  localparam int CPB = 10;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx[3], rdy[3], oclr[3];
  logic [7:0] w_data[3];
  logic w_val[3], w_pe[3], w_fe[3], w_ovr[3], w_busy[3];
  exp_t q[3][$];
  bit held[3], ovr_exp[3];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_rx_param_if #(.DATA_BITS(8)) b0 ();
  uart_rx_param_if #(.DATA_BITS(7)) b1 ();
  uart_rx_param_if #(.DATA_BITS(8)) b2 ();
  assign b0.rx_ready = rdy[0];
  assign b1.rx_ready = rdy[1];
  assign b2.rx_ready = rdy[2];
  assign {w_data[0], w_val[0], w_pe[0], w_fe[0]} = {b0.rx_data, b0.rx_valid, b0.parity_err, b0.frame_err};
  assign {w_data[1], w_val[1], w_pe[1], w_fe[1]} = {1'b0, b1.rx_data, b1.rx_valid, b1.parity_err, b1.frame_err};
  assign {w_data[2], w_val[2], w_pe[2], w_fe[2]} = {b2.rx_data, b2.rx_valid, b2.parity_err, b2.frame_err};
  uart_rx_param #(.CLK_FREQ(50000000), .BAUD_RATE(5000000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .overrun_clr(oclr[0]), .bus(b0), .overrun(w_ovr[0]), .busy(w_busy[0]));
  uart_rx_param #(.CLK_FREQ(50000000), .BAUD_RATE(5000000), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .overrun_clr(oclr[1]), .bus(b1), .overrun(w_ovr[1]), .busy(w_busy[1]));
  uart_rx_param #(.CLK_FREQ(50000000), .BAUD_RATE(5000000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .overrun_clr(oclr[2]), .bus(b2), .overrun(w_ovr[2]), .busy(w_busy[2]));

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic mon(input int c);
    exp_t e;
    n_tests++;
    if (q[c].size() == 0) begin
      n_fail++;
      $display("FAIL frame_ch%0d: got data %02h pe %0d fe %0d, expected no frame", c, w_data[c], w_pe[c], w_fe[c]);
    end else begin
      e = q[c].pop_front();
      if ({w_data[c], w_pe[c], w_fe[c]} != e) begin
        n_fail++;
        $display("FAIL frame_ch%0d: got data %02h pe %0d fe %0d, expected data %02h pe %0d fe %0d",
                 c, w_data[c], w_pe[c], w_fe[c], e.d, e.pe, e.fe);
      end
    end
  endtask

  // monitor: every accepted frame is checked against the head of its channel queue
  always @(negedge clk)
    for (int c = 0; c < 3; c++)
      if (!rst && w_val[c] && rdy[c]) mon(c);

  // drive one frame, called at a negedge; gb = wire bit to glitch at offset 6, cut = stop after that many bits
  task automatic send(input int ch, input logic [7:0] d, input int nb, input int pm, input bit flip,
                      input logic [1:0] st, input int ns, input int gb, input int cut);
    logic [7:0] dm;
    logic pb;
    logic bits[$];
    exp_t e;
    int nbits;
    dm = d & 8'((1 << nb) - 1);
    pb = (pm == 1 ? ^dm : ~^dm) ^ flip;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
    if (pm != 0) bits.push_back(pb);
    for (int i = 0; i < ns; i++) bits.push_back(st[i]);
    if (cut == 0) begin
      e.d  = dm;
      if (MAJ == 0 && gb >= 1 && gb <= nb) e.d[gb-1] = ~e.d[gb-1];
      e.pe = (pm == 0) ? 1'b0 : ((($countones(dm) + int'(pb)) % 2) != (pm == 2 ? 1 : 0));
      e.fe = (ns == 1) ? ~st[0] : ~(st[0] & st[1]);
      if (held[ch]) ovr_exp[ch] = 1'b1;
      else begin
        q[ch].push_back(e);
        held[ch] = !rdy[ch];
      end
    end
    nbits = (cut > 0) ? cut : bits.size();
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < CPB; c++) begin
        rx[ch] = (b == gb && c == 6) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    rx[ch] = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 3; c++) begin
      rx[c] = 1'b1; rdy[c] = 1'b1; oclr[c] = 1'b0; held[c] = 1'b0; ovr_exp[c] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("reset_valid_ch%0d", c), int'(w_val[c]), 0);
      chk($sformatf("reset_busy_ch%0d", c), int'(w_busy[c]), 0);
      chk($sformatf("reset_overrun_ch%0d", c), int'(w_ovr[c]), 0);
      chk($sformatf("reset_data_ch%0d", c), int'(w_data[c]), 0);
      chk($sformatf("reset_flags_ch%0d", c), int'({w_pe[c], w_fe[c]}), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // 8N1 0xA5 and its pin-to-valid latency
    fork
      send(0, 8'hA5, 8, 0, 0, 2'b11, 1, -1, 0);
      begin
        int n;
        n = 0;
        while (!w_val[0] && n < 300) begin
          @(negedge clk);
          n++;
        end
        chk("latency_8n1", n, 10 * 9 + 5 + 4 + MAJ);
      end
    join
    repeat (5) @(negedge clk);
    // 7E1 good then bad parity
    send(1, 8'h35, 7, 1, 0, 2'b11, 1, -1, 0);
    send(1, 8'h35, 7, 1, 1, 2'b11, 1, -1, 0);
    // 8N2 low second stop, then clean frames, the last two back-to-back
    send(2, 8'h3C, 8, 0, 0, 2'b01, 2, -1, 0);
    repeat (CPB) @(negedge clk);
    send(2, 8'h00, 8, 0, 0, 2'b11, 2, -1, 0);
    send(2, 8'hC3, 8, 0, 0, 2'b11, 2, -1, 0);
    repeat (20) @(negedge clk);
    // false start: 3-clk low glitch
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx[0] = 1'b1;
    @(negedge clk);
    chk("false_start_busy_rise", int'(w_busy[0]), 1);
    repeat (30) @(negedge clk);
    chk("false_start_busy_fall", int'(w_busy[0]), 0);
    chk("false_start_no_valid", int'(w_val[0]), 0);
    // break: one zero frame with frame error, no retrigger while low
    q[0].push_back({8'h00, 1'b0, 1'b1});
    rx[0] = 1'b0;
    repeat (140) @(negedge clk);
    chk("break_no_retrigger", int'(w_busy[0]), 0);
    repeat (10) @(negedge clk);
    rx[0] = 1'b1;
    repeat (20) @(negedge clk);
    send(0, 8'h66, 8, 0, 0, 2'b11, 1, -1, 0);
    repeat (10) @(negedge clk);
    // overrun with rx_ready low
    @(posedge clk); #2 rdy[0] = 1'b0;
    @(negedge clk);
    send(0, 8'h11, 8, 0, 0, 2'b11, 1, -1, 0);
    send(0, 8'h22, 8, 0, 0, 2'b11, 1, -1, 0);
    repeat (5) @(negedge clk);
    chk("overrun_hold_data", int'(w_data[0]), 8'h11);
    chk("overrun_hold_valid", int'(w_val[0]), 1);
    chk("overrun_set", int'(w_ovr[0]), int'(ovr_exp[0]));
    @(posedge clk); #2 rdy[0] = 1'b1;
    held[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("overrun_valid_drop", int'(w_val[0]), 0);
    chk("overrun_sticky", int'(w_ovr[0]), int'(ovr_exp[0]));
    @(posedge clk); #2 oclr[0] = 1'b1;
    @(posedge clk); #2 oclr[0] = 1'b0;
    ovr_exp[0] = 1'b0;
    @(negedge clk);
    chk("overrun_clear", int'(w_ovr[0]), int'(ovr_exp[0]));
    // reset during data bit 4
    send(0, 8'hC7, 8, 0, 0, 2'b11, 1, -1, 5);
    chk("midframe_busy", int'(w_busy[0]), 1);
    rst = 1'b1;
    #1;
    chk("async_reset_busy", int'(w_busy[0]), 0);
    chk("async_reset_data", int'(w_data[0]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin held[c] = 1'b0; ovr_exp[c] = 1'b0; end
    send(0, 8'h5A, 8, 0, 0, 2'b11, 1, -1, 0);
    repeat (10) @(negedge clk);
    // one-clock glitch at the mid of data bit 3
    send(0, 8'h96, 8, 0, 0, 2'b11, 1, 4, 0);
    repeat (10) @(negedge clk);
    // randomized traffic on all three receivers in parallel
    fork
      for (int i = 0; i < 10; i++) begin
        logic lo0;
        lo0 = ($urandom_range(3) == 0);
        send(0, 8'($urandom), 8, 0, 0, {1'b1, ~lo0}, 1, -1, 0);
        repeat (lo0 ? 12 : $urandom_range(8)) @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
        send(1, 8'($urandom), 7, 1, 1'($urandom_range(1)), 2'b11, 1, -1, 0);
        repeat ($urandom_range(8)) @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
        logic [1:0] st2;
        st2 = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b11;
        send(2, 8'($urandom), 8, 0, 0, st2, 2, -1, 0);
        repeat (!st2[1] ? 12 : $urandom_range(8)) @(negedge clk);
      end
    join
    begin
      int t;
      t = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 1000) begin
        @(negedge clk);
        t++;
      end
    end
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("queue_drained_ch%0d", c), q[c].size(), 0);
      chk($sformatf("final_overrun_ch%0d", c), int'(w_ovr[c]), int'(ovr_exp[c]));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
